// File: rtl/paicore_recv_pkg.sv
// Shared definitions for the PAICORE receive-merge path.
//   recv_state_e     : frame state (RUN, FLUSH, PAD, DONE), exposed on dbg_state
//   WORD_W           : width of one core channel word
//   PAD_WORD_DEFAULT : default padding beat value
//   rr_next()        : round-robin successor index with wrap
package paicore_recv_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_PAD   = 2'd2,
      ST_DONE  = 2'd3
   } recv_state_e;

   localparam int          WORD_W           = 32;
   localparam logic [63:0] PAD_WORD_DEFAULT = 64'h0;

   // Index following cur in a ring of n entries.
   function automatic int rr_next(input int cur, input int n);
      return (cur + 1 >= n) ? 0 : cur + 1;
   endfunction

endpackage

// File: rtl/paicore_recv_chan_pack.sv
// One core output channel: request synchroniser, 4-phase acknowledge and
// a pack register that gathers WORD_RATIO words into one output beat.
//   clk, rst_n    : clock, asynchronous active-low reset
//   en            : channel enable; a disabled channel never acknowledges
//   request, din  : asynchronous 4-phase request and its 32-bit word
//   acknowledge   : 4-phase acknowledge back to the core
//   grant         : pack consumed by the arbiter this cycle
//   pack_data     : gathered words, slot 0 in the LSBs, unused slots zero
//   pack_full     : all WORD_RATIO slots filled
//   pack_partial  : at least one slot filled, not full
module paicore_recv_chan_pack
   import paicore_recv_pkg::*;
#(
   parameter int WORD_RATIO  = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           en,
   input  logic                           request,
   input  logic [WORD_W-1:0]              din,
   input  logic                           grant,
   output logic                           acknowledge,
   output logic [WORD_RATIO*WORD_W-1:0]   pack_data,
   output logic                           pack_full,
   output logic                           pack_partial
);

   localparam int KW = $clog2(WORD_RATIO + 1);

   logic [SYNC_STAGES-1:0]          sync_q;
   logic [KW-1:0]                   cnt_q;
   logic [WORD_RATIO*WORD_W-1:0]    pack_q;
   logic                            ack_q;
   logic                            sync_req;
   logic                            capture;

   assign sync_req     = sync_q[SYNC_STAGES-1];
   assign pack_full    = (cnt_q == KW'(WORD_RATIO));
   assign pack_partial = (cnt_q != '0) && !pack_full;
   // A full pack holds off the acknowledge so the core stalls until the
   // arbiter takes the pack. A capture is also skipped in the grant cycle
   // so the clear and the write never collide; it happens one cycle later.
   assign capture      = en && sync_req && !ack_q && !pack_full && !grant;

   assign acknowledge  = ack_q;
   assign pack_data    = pack_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], request};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         pack_q <= '0;
         ack_q  <= 1'b0;
      end else begin
         if (grant) begin
            // Clearing the data keeps unused upper slots zero for partial flushes.
            cnt_q  <= '0;
            pack_q <= '0;
         end else if (capture) begin
            for (int s = 0; s < WORD_RATIO; s++) begin
               if (int'(cnt_q) == s) pack_q[s*WORD_W +: WORD_W] <= din;
            end
            cnt_q <= cnt_q + KW'(1);
         end

         if (capture) begin
            ack_q <= 1'b1;
         end else if (!sync_req && ack_q) begin
            ack_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/paicore_recv_merge.sv
// PAICORE receive merge: gathers 32-bit words from CHANNEL asynchronous
// 4-phase core channels into DATA_WIDTH beats, round-robins the enabled
// channels onto one AXI-Stream master, pads each frame to oFrameNumMax
// beats and marks the final beat with tlast.
//   m_axis_aclk, m_axis_aresetn : clock, asynchronous active-low reset
//   ien                         : per-channel enable
//   oFrameNumMax                : beats per frame, 0 = no padding
//   request, din, acknowledge   : per-channel 4-phase word interface
//   i_recv_done                 : end-of-receive pulse, starts the flush
//   m_axis_t*                   : AXI-Stream master
//   snn_out_hsked, read_hsked   : data-beat / any-beat handshake pulses
//   beat_cnt                    : beats handshaked in the current frame
//   o_rx_done                   : one-cycle pulse when a frame completes
//   dbg_state                   : current frame state
//
// Stream handshake: a beat transfers at a rising edge where tvalid and
// tready are both high. Once tvalid is raised it stays high, and tdata and
// tlast stay unchanged, until that transfer happens; tready may toggle freely.
module paicore_recv_merge
   import paicore_recv_pkg::*;
#(
   parameter int          CHANNEL     = 4,
   parameter int          DATA_WIDTH  = 64,
   parameter int          SYNC_STAGES = 2,
   parameter logic [63:0] PAD_WORD    = PAD_WORD_DEFAULT
) (
   input  logic                        m_axis_aclk,
   input  logic                        m_axis_aresetn,
   input  logic [CHANNEL-1:0]          ien,
   input  logic [31:0]                 oFrameNumMax,
   input  logic [CHANNEL-1:0]          request,
   input  logic [CHANNEL*WORD_W-1:0]   din,
   output logic [CHANNEL-1:0]          acknowledge,
   input  logic                        i_recv_done,
   input  logic                        m_axis_tready,
   output logic [DATA_WIDTH-1:0]       m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic                        m_axis_tlast,
   output logic                        snn_out_hsked,
   output logic                        read_hsked,
   output logic [31:0]                 beat_cnt,
   output logic                        o_rx_done,
   output recv_state_e                 dbg_state
);

   localparam int WORD_RATIO = DATA_WIDTH / WORD_W;
   localparam int PW         = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;

   logic [DATA_WIDTH-1:0] pack_data [CHANNEL];
   logic [CHANNEL-1:0]    pack_full;
   logic [CHANNEL-1:0]    pack_partial;
   logic [CHANNEL-1:0]    grant_vec;

   recv_state_e           state_q;
   logic [PW-1:0]         rr_ptr_q;
   logic [31:0]           frame_max_q;
   logic                  shadow_ld_q;
   logic [31:0]           loaded_cnt_q;
   logic [31:0]           beat_cnt_q;
   logic                  last_pend_q;
   logic                  o_rx_done_q;
   logic                  out_valid_q;
   logic                  out_last_q;
   logic                  out_is_data_q;
   logic [DATA_WIDTH-1:0] out_data_q;

   logic [CHANNEL-1:0]    eligible;
   logic                  arb_en;
   logic                  found;
   logic                  grant_valid;
   int                    grant_idx;
   int                    idx;
   logic [31:0]           frame_max;
   logic [31:0]           next_cnt;
   logic                  load_ok;
   logic                  hs;
   logic                  pad_load;
   logic                  data_last;
   logic                  pad_last;
   logic [DATA_WIDTH-1:0] pad_beat;

   for (genvar c = 0; c < CHANNEL; c++) begin : g_chan
      paicore_recv_chan_pack #(
         .WORD_RATIO  (WORD_RATIO),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_pack (
         .clk          (m_axis_aclk),
         .rst_n        (m_axis_aresetn),
         .en           (ien[c]),
         .request      (request[c]),
         .din          (din[c*WORD_W +: WORD_W]),
         .grant        (grant_vec[c]),
         .acknowledge  (acknowledge[c]),
         .pack_data    (pack_data[c]),
         .pack_full    (pack_full[c]),
         .pack_partial (pack_partial[c])
      );
   end

   // The padding word is repeated or truncated to the beat width.
   always_comb begin
      pad_beat = '0;
      for (int b = 0; b < DATA_WIDTH; b++) pad_beat[b] = PAD_WORD[b % 64];
   end

   // The frame length is taken live in the first RUN cycle so a beat loaded
   // in that same cycle already sees the new value.
   assign frame_max = shadow_ld_q ? oFrameNumMax : frame_max_q;
   assign next_cnt  = loaded_cnt_q + 32'd1;
   assign load_ok   = !out_valid_q || m_axis_tready;
   assign hs        = out_valid_q && m_axis_tready;
   assign data_last = (frame_max != 32'd0) && (next_cnt == frame_max);
   assign pad_last  = (frame_max == 32'd0) || (next_cnt == frame_max);
   assign pad_load  = (state_q == ST_PAD) && !last_pend_q && load_ok;

   // Round-robin arbiter. Partial packs only compete while flushing; once
   // the tlast beat is loaded nothing more is granted until DONE is left.
   always_comb begin
      eligible    = ien & (pack_full | (pack_partial & {CHANNEL{state_q == ST_FLUSH}}));
      arb_en      = load_ok && !last_pend_q && (state_q == ST_RUN || state_q == ST_FLUSH);
      found       = 1'b0;
      grant_idx   = 0;
      idx         = int'(rr_ptr_q);
      for (int i = 0; i < CHANNEL; i++) begin
         if (!found && eligible[idx]) begin
            found     = 1'b1;
            grant_idx = idx;
         end
         idx = rr_next(idx, CHANNEL);
      end
      grant_valid = found && arb_en;
      for (int c = 0; c < CHANNEL; c++) grant_vec[c] = grant_valid && (grant_idx == c);
   end

   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         state_q       <= ST_RUN;
         rr_ptr_q      <= '0;
         frame_max_q   <= '0;
         shadow_ld_q   <= 1'b1;
         loaded_cnt_q  <= '0;
         beat_cnt_q    <= '0;
         last_pend_q   <= 1'b0;
         o_rx_done_q   <= 1'b0;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
         out_is_data_q <= 1'b0;
         out_data_q    <= '0;
      end else begin
         shadow_ld_q <= 1'b0;
         o_rx_done_q <= 1'b0;
         if (shadow_ld_q) frame_max_q <= oFrameNumMax;

         // 1-deep output register, reloaded in the handshake cycle so full
         // throughput has no bubbles.
         if (grant_valid) begin
            out_valid_q   <= 1'b1;
            out_data_q    <= pack_data[grant_idx];
            out_last_q    <= data_last;
            out_is_data_q <= 1'b1;
            loaded_cnt_q  <= next_cnt;
            rr_ptr_q      <= PW'(rr_next(grant_idx, CHANNEL));
            if (data_last) last_pend_q <= 1'b1;
         end else if (pad_load) begin
            out_valid_q   <= 1'b1;
            out_data_q    <= pad_beat;
            out_last_q    <= pad_last;
            out_is_data_q <= 1'b0;
            loaded_cnt_q  <= next_cnt;
            if (pad_last) last_pend_q <= 1'b1;
         end else if (hs) begin
            out_valid_q   <= 1'b0;
         end

         if (hs) beat_cnt_q <= beat_cnt_q + 32'd1;

         case (state_q)
            ST_RUN: begin
               if (hs && out_last_q) begin
                  state_q     <= ST_DONE;
                  o_rx_done_q <= 1'b1;
               end else if (i_recv_done && !last_pend_q && !(grant_valid && data_last)) begin
                  state_q <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (hs && out_last_q) begin
                  state_q     <= ST_DONE;
                  o_rx_done_q <= 1'b1;
               end else if (!last_pend_q && eligible == '0) begin
                  state_q <= ST_PAD;
               end
            end
            ST_PAD: begin
               if (hs && out_last_q) begin
                  state_q     <= ST_DONE;
                  o_rx_done_q <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q      <= ST_RUN;
               beat_cnt_q   <= '0;
               loaded_cnt_q <= '0;
               last_pend_q  <= 1'b0;
               shadow_ld_q  <= 1'b1;
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign m_axis_tdata  = out_data_q;
   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tlast  = out_last_q;
   assign read_hsked    = hs;
   assign snn_out_hsked = hs && out_is_data_q;
   assign beat_cnt      = beat_cnt_q;
   assign o_rx_done     = o_rx_done_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_paicore_recv_merge.sv
module tb_paicore_recv_merge;
   import paicore_recv_pkg::*;

   localparam int CHANNEL = 4;
   localparam int DW      = 64;
   localparam int EW      = 66;   // {is_data, last, data}

   logic                   clk;
   logic                   rst_n;
   logic [CHANNEL-1:0]     ien;
   logic [31:0]            oFrameNumMax;
   logic [CHANNEL-1:0]     request;
   logic [CHANNEL*32-1:0]  din;
   logic [CHANNEL-1:0]     acknowledge;
   logic                   i_recv_done;
   logic                   m_axis_tready;
   logic [DW-1:0]          m_axis_tdata;
   logic                   m_axis_tvalid;
   logic                   m_axis_tlast;
   logic                   snn_out_hsked;
   logic                   read_hsked;
   logic [31:0]            beat_cnt;
   logic                   o_rx_done;
   recv_state_e            dbg_state;

   logic [EW-1:0] exp_q[$];
   int            n_checks;
   int            n_pass;
   int            rd_cnt;
   int            snn_cnt;
   int            stall_cnt;
   logic          stall_pend;
   logic [DW-1:0] hold_data;
   logic          hold_last;

   paicore_recv_merge #(
      .CHANNEL     (CHANNEL),
      .DATA_WIDTH  (DW),
      .SYNC_STAGES (2),
      .PAD_WORD    (64'h0)
   ) dut (
      .m_axis_aclk    (clk),
      .m_axis_aresetn (rst_n),
      .ien            (ien),
      .oFrameNumMax   (oFrameNumMax),
      .request        (request),
      .din            (din),
      .acknowledge    (acknowledge),
      .i_recv_done    (i_recv_done),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tlast   (m_axis_tlast),
      .snn_out_hsked  (snn_out_hsked),
      .read_hsked     (read_hsked),
      .beat_cnt       (beat_cnt),
      .o_rx_done      (o_rx_done),
      .dbg_state      (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      request     = '0;
      i_recv_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_tdata", m_axis_tdata, 64'd0);
      check("rst_tlast", 64'(m_axis_tlast), 64'd0);
      check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
      check("rst_rx_done", 64'(o_rx_done), 64'd0);
      check("rst_ack", 64'(acknowledge), 64'd0);
      check("rst_hsked", 64'({snn_out_hsked, read_hsked}), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(ST_RUN));
      exp_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      rd_cnt  = 0;
      snn_cnt = 0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_ack(input int ch, input logic val, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (acknowledge[ch] == val) break;
      end
      check("ack_wait", 64'(acknowledge[ch]), 64'(val));
   endtask

   task automatic send_word(input int ch, input logic [31:0] w);
      @(posedge clk);
      #1;
      din[ch*32 +: 32] = w;
      request[ch]      = 1'b1;
      wait_ack(ch, 1'b1, 40);
      @(posedge clk);
      #1 request[ch] = 1'b0;
      wait_ack(ch, 1'b0, 40);
   endtask

   function automatic void push_exp(input logic is_data, input logic last, input logic [63:0] data);
      exp_q.push_back({is_data, last, data});
   endfunction

   // Expected beat is queued before the words go out: the beat can leave
   // the DUT before the last 4-phase cycle has finished.
   task automatic fill_pack(input int ch, input logic last);
      logic [31:0] w0;
      logic [31:0] w1;
      w0 = $urandom();
      w1 = $urandom();
      push_exp(1'b1, last, {w1, w0});
      send_word(ch, w0);
      send_word(ch, w1);
   endtask

   task automatic pulse_done();
      @(posedge clk);
      #1 i_recv_done = 1'b1;
      @(posedge clk);
      #1 i_recv_done = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (o_rx_done) begin
            seen = 1'b1;
            break;
         end
      end
      check("rx_done", 64'(seen), 64'd1);
   endtask

   task automatic drain();
      repeat (5) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            check("hold_valid", 64'(m_axis_tvalid), 64'd1);
            check("hold_data", m_axis_tdata, hold_data);
            check("hold_last", 64'(m_axis_tlast), 64'(hold_last));
         end
         if (m_axis_tvalid && m_axis_tready) begin
            check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               logic [EW-1:0] e;
               e = exp_q.pop_front();
               check("beat_data", m_axis_tdata, e[63:0]);
               check("beat_last", 64'(m_axis_tlast), 64'(e[64]));
               check("beat_snn_hsked", 64'(snn_out_hsked), 64'(e[65]));
               check("beat_read_hsked", 64'(read_hsked), 64'd1);
            end
         end
         if (read_hsked) rd_cnt++;
         if (snn_out_hsked) snn_cnt++;
         stall_pend = m_axis_tvalid && !m_axis_tready;
         if (stall_pend) stall_cnt++;
         hold_data = m_axis_tdata;
         hold_last = m_axis_tlast;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic        seen;
      logic [31:0] w;
      n_checks      = 0;
      n_pass        = 0;
      rd_cnt        = 0;
      snn_cnt       = 0;
      stall_cnt     = 0;
      stall_pend    = 1'b0;
      hold_data     = '0;
      hold_last     = 1'b0;
      rst_n         = 1'b0;
      ien           = '1;
      oFrameNumMax  = 32'd0;
      request       = '0;
      din           = '0;
      i_recv_done   = 1'b0;
      m_axis_tready = 1'b1;

      // 1: no padding, one data beat then a single tlast pad beat.
      oFrameNumMax = 32'd0;
      do_reset();
      push_exp(1'b1, 1'b0, 64'h22222222_11111111);
      send_word(0, 32'h11111111);
      send_word(0, 32'h22222222);
      push_exp(1'b0, 1'b1, 64'h0);
      pulse_done();
      wait_done(200);
      drain();

      // 2: four full packs plus a refilled channel 0 drain back to back.
      do_reset();
      m_axis_tready = 1'b0;
      for (int c = 0; c < CHANNEL; c++) fill_pack(c, 1'b0);
      fill_pack(0, 1'b0);
      @(posedge clk);
      #1 m_axis_tready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("no_bubble", 64'(m_axis_tvalid), 64'd1);
      end
      push_exp(1'b0, 1'b1, 64'h0);
      pulse_done();
      wait_done(200);
      drain();

      // 3: frame of 5 beats, 2 data then 3 pad.
      oFrameNumMax = 32'd5;
      do_reset();
      fill_pack(0, 1'b0);
      fill_pack(0, 1'b0);
      push_exp(1'b0, 1'b0, 64'h0);
      push_exp(1'b0, 1'b0, 64'h0);
      push_exp(1'b0, 1'b1, 64'h0);
      pulse_done();
      wait_done(200);
      check("beat_cnt_at_done", 64'(beat_cnt), 64'd5);
      @(negedge clk);
      check("beat_cnt_cleared", 64'(beat_cnt), 64'd0);
      check("read_hsked_count", 64'(rd_cnt), 64'd5);
      check("snn_hsked_count", 64'(snn_cnt), 64'd2);
      drain();

      // 4: frame of 3 with four packs pending; the fourth waits for DONE.
      oFrameNumMax = 32'd3;
      do_reset();
      m_axis_tready = 1'b0;
      fill_pack(0, 1'b0);
      fill_pack(1, 1'b0);
      fill_pack(2, 1'b1);
      fill_pack(3, 1'b0);
      @(posedge clk);
      #1;
      din[3*32 +: 32] = $urandom();
      request[3]      = 1'b1;
      m_axis_tready   = 1'b1;
      wait_done(200);
      check("held_ack", 64'(acknowledge[3]), 64'd0);
      wait_ack(3, 1'b1, 60);
      @(posedge clk);
      #1 request[3] = 1'b0;
      wait_ack(3, 1'b0, 60);
      drain();

      // 5: tready toggling every cycle against a queue of full packs.
      oFrameNumMax = 32'd0;
      do_reset();
      m_axis_tready = 1'b0;
      for (int c = 0; c < CHANNEL; c++) fill_pack(c, 1'b0);
      stall_cnt = 0;
      for (int i = 0; i < 24; i++) begin
         @(posedge clk);
         #1 m_axis_tready = ~m_axis_tready;
      end
      @(posedge clk);
      #1 m_axis_tready = 1'b1;
      check("stall_seen", 64'(stall_cnt > 0), 64'd1);
      push_exp(1'b0, 1'b1, 64'h0);
      pulse_done();
      wait_done(200);
      drain();

      // 6: disabled channel never acknowledges; single word flushes zero-filled.
      ien          = 4'b1011;
      oFrameNumMax = 32'd0;
      do_reset();
      @(posedge clk);
      #1;
      din[2*32 +: 32] = $urandom();
      request[2]      = 1'b1;
      repeat (12) @(negedge clk);
      check("ien_block", 64'(acknowledge[2]), 64'd0);
      @(posedge clk);
      #1 request[2] = 1'b0;
      w = $urandom();
      push_exp(1'b1, 1'b0, {32'h0, w});
      send_word(1, w);
      push_exp(1'b0, 1'b1, 64'h0);
      pulse_done();
      wait_done(200);
      drain();
      ien = '1;

      // 7: reset while a pad beat is stalled, then a clean frame.
      oFrameNumMax = 32'd8;
      do_reset();
      fill_pack(0, 1'b0);
      repeat (6) @(negedge clk);
      @(posedge clk);
      #1 m_axis_tready = 1'b0;
      pulse_done();
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (dbg_state == ST_PAD && m_axis_tvalid) begin
            seen = 1'b1;
            break;
         end
      end
      check("reach_pad", 64'(seen), 64'd1);
      check("queue_before_abort", 64'(exp_q.size()), 64'd0);
      #2 rst_n = 1'b0;
      oFrameNumMax = 32'd0;
      #1;
      check("abort_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("abort_tdata", m_axis_tdata, 64'd0);
      check("abort_tlast", 64'(m_axis_tlast), 64'd0);
      check("abort_beat_cnt", 64'(beat_cnt), 64'd0);
      check("abort_rx_done", 64'(o_rx_done), 64'd0);
      m_axis_tready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (o_rx_done || m_axis_tvalid) seen = 1'b1;
      end
      check("quiet_after_abort", 64'(seen), 64'd0);
      check("fresh_beat_cnt", 64'(beat_cnt), 64'd0);
      fill_pack(0, 1'b0);
      repeat (4) @(negedge clk);
      check("beat_cnt_one", 64'(beat_cnt), 64'd1);
      push_exp(1'b0, 1'b1, 64'h0);
      pulse_done();
      wait_done(200);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
